md6_cf_iter: RTL and testbench
==============================

Name: md6_cf_iter

Overview:
- Iterative MD6 compression-function engine.
- Acts as the responder on the start/done handshake driven by the MD6 mode controllers (SEQ, PAR).
- Builds the 89-word input block N = Q‖K‖U‖V‖B from the controller's operands, runs 16·r MD6 steps at one step per clock, and returns the 16-word chaining value C.

Parameters:
W, 64, word width in bits; only 64 supported.
RMAX, 168, maximum accepted round count; larger r is clamped to RMAX.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  start request; level, held by initiator until done seen
index  in  56  node index, U word bits 55:0
level  in  8  node level, U word bits 63:56
Level  in  8  max level L, V field
z_end  in  4  final-node flag z, V field
r  in  12  round count
d  in  12  digest length, V field
M_in  in  4096  data block B; word j = M_in[64j+:64]
padding_zero_M  in  16  padding bit count p, V field
K  in  512  key; word j = K[64j+:64]
keylen  in  8  key length in bytes, V field
done  out  1  result valid
C  out  1024  chaining value; word j = C[64j+:64]

Behaviour:
- One clock domain (clk). reset is asynchronous, active-high. Reset clears state to IDLE, done=0, C=0, shift register=0, step counter=0.
- States: IDLE, RUN, DONE.
- IDLE → RUN when enable=1 at a clock edge. On that same edge:
  - Load shift register sr[0..88] with N.
  - N[0..14] = Q constants; Q[0] = 0x7311c2812425cfa0.
  - N[15..22] = K words 0..7.
  - N[23] = U = {level, index}.
  - N[24] = V = {4'b0, r, Level, z_end, padding_zero_M, keylen, d}, MSB first.
  - N[25..88] = M_in words 0..63.
  - Latch rr = min(r, RMAX).
  - Clear step counter s. Set S = 0x0123456789abcdef.
- RUN, one step per cycle, with j = s mod 16:
  - x = S ^ sr[0] ^ sr[72] ^ (sr[71] & sr[68]) ^ (sr[58] & sr[22])
  - x ^= x >> R[j]
  - x ^= x << Lsh[j]
  - Shift: sr[k] ← sr[k+1]; sr[88] ← x. Then s ← s+1.
  - R = {10,5,13,10,11,12,2,7,14,15,7,13,11,7,6,12}.
  - Lsh = {11,24,9,16,15,9,27,15,6,2,29,8,15,5,31,9}.
  - When j = 15: S ← rotl(S,1) ^ (S & 0x7311c2812425cfa0).
- RUN → DONE on the edge that completes step 16·rr−1.
  - If rr = 0, RUN lasts one idle cycle with no step performed.
  - On entering DONE: C ← {sr[88], …, sr[73]}, i.e. C word j = sr[73+j].
- DONE: done=1, C held stable.
  - DONE → IDLE when enable=0 is sampled; done clears on that edge.
  - C keeps its value until the next completed operation or reset.
- Latency, counted from the accepting edge (edge 0): done is high after edge 16·rr+1. For rr=0, done is high after edge 2.
- enable is ignored during RUN. Dropping it mid-RUN does not abort. DONE then lasts exactly one cycle.
- enable held high in DONE keeps done high; no re-trigger occurs until done has dropped.
- Operand inputs are sampled only on the accepting edge and may change afterwards.
- r > 168 is clamped to 168 for the step count; the V word still carries the raw r.
- Reset mid-RUN or in DONE aborts immediately. done=0 asynchronously.
- Handshake with the controllers: the initiator drops enable the cycle after it sees done. The engine returns to IDLE before the initiator's next enable pulse, so a new block is accepted with no lost cycle.

Test Plan:
- r=0, M_in word j = j+1 → done high after edge 2; C words 0..15 = 49..64; done clears one edge after enable drops.
- r=5, random operands → done rises exactly 81 edges after acceptance; C matches the team's C MD6 compression model bit-exact. Repeat for r=1, r=80 and r=168.
- r=200 → done after 16·168+1 edges; V word in the model uses 200; C matches the model.
- Assert reset at step 37 of an r=10 run → done=0 and C=0 immediately. Restart with the same operands → same result as an uninterrupted run.
- Drop enable at step 3 of an r=2 run → done high for exactly one cycle after edge 33, then IDLE. Hold enable high through DONE instead → done stays high with no second run.
- Drive SEQ-style back-to-back chaining of 3 blocks (enable drops for one cycle between blocks) → each block accepted. Final C equals the model's chained result, with index 0, 1, 2 in U.

Source files
------------

// File: rtl/md6_cf_iter.sv
// md6_cf_iter: iterative MD6 compression function, one step per clock.
// Builds N = Q|K|U|V|B on start, runs 16*r steps, returns 16-word C.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   enable              start request (level, held until done seen)
//   index, level        U word {level, index}
//   Level, z_end, r, d  V fields (r also gives the round count)
//   padding_zero_M      V field p
//   keylen              V field key length in bytes
//   M_in, K             data block B (64 words), key (8 words)
//   done, C             result valid, chaining value (16 words)
module md6_cf_iter #(
    parameter int W    = 64,
    parameter int RMAX = 168
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [55:0]   index,
    input  logic [7:0]    level,
    input  logic [7:0]    Level,
    input  logic [3:0]    z_end,
    input  logic [11:0]   r,
    input  logic [11:0]   d,
    input  logic [4095:0] M_in,
    input  logic [15:0]   padding_zero_M,
    input  logic [511:0]  K,
    input  logic [7:0]    keylen,
    output logic          done,
    output logic [1023:0] C
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [W-1:0] S0 = 64'h0123456789abcdef;

    // Q[0] is the least significant word.
    localparam logic [14:0][W-1:0] Q = {
        64'h0d6f3522631effcb, 64'h3b72066c7a1552ac,
        64'hc878c1dd04c4b633, 64'h995ad1178bd25c31,
        64'h8af8671d3fb50c2c, 64'h3e7f16bb88222e0d,
        64'h4ad12aae0a6d6031, 64'h54e5ed5b88e3775d,
        64'h1f8ccf6823058f8a, 64'h0cd0d63b2c30bc41,
        64'hdd2e76cba691e5bf, 64'he8fb23908d9f06f1,
        64'hb60450e9ef68b7c1, 64'h6432286434aac8e7,
        64'h7311c2812425cfa0
    };

    // Per-step shift amounts, entry 0 least significant.
    localparam logic [15:0][3:0] RSH = {
        4'd12, 4'd6,  4'd7,  4'd11, 4'd13, 4'd7,  4'd15, 4'd14,
        4'd7,  4'd2,  4'd12, 4'd11, 4'd10, 4'd13, 4'd5,  4'd10
    };
    localparam logic [15:0][4:0] LSH = {
        5'd9,  5'd31, 5'd5,  5'd15, 5'd8,  5'd29, 5'd2,  5'd6,
        5'd15, 5'd27, 5'd9,  5'd15, 5'd16, 5'd9,  5'd24, 5'd11
    };

    state_t state, state_nxt;

    logic [88:0][W-1:0] sr;
    logic [88:0][W-1:0] sr_d;
    logic [11:0]        s;
    logic [7:0]         rr;
    logic [W-1:0]       S;
    logic [W-1:0]       x0, x1, x;
    logic [W-1:0]       v_word;
    logic [3:0]         j;
    logic [11:0]        nsteps;
    logic               last;
    logic               load, step, cap;

    assign j      = s[3:0];
    assign nsteps = {rr, 4'b0000};
    assign last   = (rr == 8'd0) || (s == nsteps - 12'd1);
    assign v_word = {4'b0000, r, Level, z_end, padding_zero_M, keylen, d};

    // Feedback word; taps are A[i-89], A[i-17], A[i-18], A[i-21],
    // A[i-31], A[i-67] seen from the head of the shift register.
    always_comb begin
        x0 = S ^ sr[0] ^ sr[72] ^ (sr[71] & sr[68]) ^ (sr[58] & sr[22]);
        x1 = x0 ^ (x0 >> RSH[j]);
        x  = x1 ^ (x1 << LSH[j]);
    end

    assign sr_d = step ? {x, sr[88:1]} : sr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (done && !enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes.
    always_comb begin
        load = (state == IDLE) && enable;
        step = (state == RUN) && (rr != 8'd0);
        cap  = (state == RUN) && last;
    end

    // Datapath. done rises one cycle after DONE is entered and only
    // leaves with the state, so DONE always shows done for >= 1 cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr   <= '0;
            s    <= '0;
            rr   <= '0;
            S    <= '0;
            C    <= '0;
            done <= 1'b0;
        end else begin
            if (load) begin
                sr <= {M_in, v_word, {level, index}, K, Q};
                rr <= (r > 12'(RMAX)) ? 8'(RMAX) : r[7:0];
                s  <= '0;
                S  <= S0;
            end else if (step) begin
                sr <= sr_d;
                s  <= s + 12'd1;
                if (j == 4'd15)
                    S <= {S[W-2:0], S[W-1]} ^ (S & Q[0]);
            end
            if (cap)
                C <= sr_d[88:73];
            done <= (state == DONE) && (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_md6_cf_iter.sv
// tb_md6_cf_iter: directed checks of md6_cf_iter against an
// array-form MD6 compression reference and hand-computed values.
module tb_md6_cf_iter;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [55:0]   index;
    logic [7:0]    level;
    logic [7:0]    Level;
    logic [3:0]    z_end;
    logic [11:0]   r;
    logic [11:0]   d;
    logic [4095:0] M_in;
    logic [15:0]   padding_zero_M;
    logic [511:0]  K;
    logic [7:0]    keylen;
    logic          done;
    logic [1023:0] C;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] QT [15] = '{
        64'h7311c2812425cfa0, 64'h6432286434aac8e7,
        64'hb60450e9ef68b7c1, 64'he8fb23908d9f06f1,
        64'hdd2e76cba691e5bf, 64'h0cd0d63b2c30bc41,
        64'h1f8ccf6823058f8a, 64'h54e5ed5b88e3775d,
        64'h4ad12aae0a6d6031, 64'h3e7f16bb88222e0d,
        64'h8af8671d3fb50c2c, 64'h995ad1178bd25c31,
        64'hc878c1dd04c4b633, 64'h3b72066c7a1552ac,
        64'h0d6f3522631effcb
    };
    localparam int RS [16] = '{10,5,13,10,11,12,2,7,14,15,7,13,11,7,6,12};
    localparam int LS [16] = '{11,24,9,16,15,9,27,15,6,2,29,8,15,5,31,9};

    logic [63:0] A [89 + 16*168];

    always #5 clk = ~clk;

    md6_cf_iter dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .index          (index),
        .level          (level),
        .Level          (Level),
        .z_end          (z_end),
        .r              (r),
        .d              (d),
        .M_in           (M_in),
        .padding_zero_M (padding_zero_M),
        .K              (K),
        .keylen         (keylen),
        .done           (done),
        .C              (C)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [1023:0] exp);
        for (int j = 0; j < 16; j++)
            chk($sformatf("%s_c%0d", tag, j), C[64*j+:64], exp[64*j+:64]);
    endtask

    // Array form: A[i] from A[i-89], A[i-17], A[i-18], A[i-21],
    // A[i-31], A[i-67]; C is the last 16 words produced.
    task automatic model(output logic [1023:0] c);
        int rr, n, t;
        logic [63:0] S, x;
        rr = (r > 12'd168) ? 168 : int'(r);
        for (int k = 0; k < 15; k++) A[k] = QT[k];
        for (int k = 0; k < 8; k++) A[15+k] = K[64*k+:64];
        A[23] = {level, index};
        A[24] = {4'b0, r, Level, z_end, padding_zero_M, keylen, d};
        for (int k = 0; k < 64; k++) A[25+k] = M_in[64*k+:64];
        S = 64'h0123456789abcdef;
        n = 16 * rr;
        for (int i = 0; i < n; i++) begin
            t = 89 + i;
            x = S ^ A[t-89] ^ A[t-17] ^ (A[t-18] & A[t-21])
                ^ (A[t-31] & A[t-67]);
            x = x ^ (x >> RS[i%16]);
            x = x ^ (x << LS[i%16]);
            A[t] = x;
            if (i % 16 == 15) S = {S[62:0], S[63]} ^ (S & QT[0]);
        end
        for (int j = 0; j < 16; j++) c[64*j+:64] = A[73+n+j];
    endtask

    function automatic int lat_of(input logic [11:0] rv);
        int rr;
        rr = (rv > 12'd168) ? 168 : int'(rv);
        return (rr == 0) ? 2 : 16 * rr + 1;
    endfunction

    task automatic set_ops(input logic [11:0] rv);
        for (int k = 0; k < 128; k++) M_in[32*k+:32] = $urandom();
        for (int k = 0; k < 16; k++) K[32*k+:32] = $urandom();
        index          = {$urandom(), $urandom()};
        level          = 8'($urandom());
        Level          = 8'($urandom());
        z_end          = 4'($urandom());
        d              = 12'($urandom());
        padding_zero_M = 16'($urandom());
        keylen         = 8'($urandom());
        r              = rv;
    endtask

    // Raises enable at posedge+1 with the DUT idle; the next edge is
    // edge 0. Returns once done is seen (or the budget runs out).
    task automatic run_op(input string tag, input int exp_lat);
        int lat;
        lat    = 0;
        enable = 1'b1;
        @(posedge clk); #1;
        while (!done && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic finish_op(input string tag);
        enable = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [1023:0] exp;
        logic [1023:0] prev;
        int lat;

        reset          = 1'b1;
        enable         = 1'b0;
        index          = '0;
        level          = '0;
        Level          = '0;
        z_end          = '0;
        r              = '0;
        d              = '0;
        M_in           = '0;
        padding_zero_M = '0;
        K              = '0;
        keylen         = '0;
        #12;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_c", 64'(|C), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // r=0: C = M words 48..63 = 49..64.
        set_ops(12'd0);
        for (int j = 0; j < 64; j++) M_in[64*j+:64] = 64'(j + 1);
        run_op("r0", 2);
        for (int j = 0; j < 16; j++)
            chk($sformatf("r0_c%0d", j), C[64*j+:64], 64'(49 + j));
        finish_op("r0");

        begin
            logic [11:0] rl [5] = '{12'd5, 12'd1, 12'd80, 12'd168, 12'd200};
            foreach (rl[i]) begin
                set_ops(rl[i]);
                model(exp);
                run_op($sformatf("r%0d", rl[i]), lat_of(rl[i]));
                chk_c($sformatf("r%0d", rl[i]), exp);
                finish_op($sformatf("r%0d", rl[i]));
            end
        end

        // Reset at step 37 of an r=10 run, then rerun the same block.
        set_ops(12'd10);
        model(exp);
        enable = 1'b1;
        @(posedge clk); #1;
        repeat (37) @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("rstmid_done", 64'(done), 64'd0);
        chk("rstmid_c", 64'(|C), 64'd0);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op("rerun", 161);
        chk_c("rerun", exp);
        finish_op("rerun");

        // Drop enable at step 3 of an r=2 run.
        set_ops(12'd2);
        model(exp);
        enable = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        lat = 3;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("drop_lat", 64'(lat), 64'd33);
        chk_c("drop", exp);
        @(posedge clk); #1;
        chk("drop_one", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_idle", 64'(done), 64'd0);

        // Hold enable through DONE: no second run.
        set_ops(12'd2);
        model(exp);
        run_op("hold", 33);
        repeat (40) @(posedge clk);
        #1;
        chk("hold_done", 64'(done), 64'd1);
        chk_c("hold", exp);
        finish_op("hold");

        // SEQ-style chaining: previous C feeds B words 0..15.
        prev = '0;
        for (int b = 0; b < 3; b++) begin
            set_ops(12'd3);
            index = 56'(b);
            M_in[1023:0] = prev;
            model(exp);
            run_op($sformatf("seq%0d", b), 49);
            chk_c($sformatf("seq%0d", b), exp);
            prev   = exp;
            enable = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("seq%0d_clr", b), 64'(done), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
